// File: rtl/level_sequencer.sv
// Game-flow controller for the Sokoban core: loads levels, gates play, holds
// win/lose banners for a fixed time, then advances, retries or reports all-clear.
module level_sequencer #(
  parameter int unsigned NUM_LEVELS  = 8,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_start,
  input  logic               key_restart,
  input  logic               win,
  input  logic               lose,
  input  logic               load_done,
  output logic [LEVEL_W-1:0] level,
  output logic               load_req,
  output logic               core_reset,
  output logic               play_en,
  output logic               show_win,
  output logic               show_lose,
  output logic               all_clear
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    WIN_HOLD  = 3'd3,
    LOSE_HOLD = 3'd4,
    DONE      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               load_req_q, load_req_d;
  logic               core_reset_q, core_reset_d;
  logic               play_en_q, play_en_d;
  logic               show_win_q, show_win_d;
  logic               show_lose_q, show_lose_d;
  logic               all_clear_q, all_clear_d;
  logic               hold_exit;

  // Banner ends on the last count or on a skip request.
  assign hold_exit = (cnt_q == HOLD_LAST) || key_start;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_start) state_d = LOAD;
      end
      LOAD: begin
        if (load_done) state_d = PLAY;
      end
      PLAY: begin
        if (win) begin
          state_d = WIN_HOLD;
          cnt_d   = '0;
        end else if (lose) begin
          state_d = LOSE_HOLD;
          cnt_d   = '0;
        end else if (key_restart) begin
          state_d = LOAD;
        end
      end
      WIN_HOLD: begin
        if (hold_exit) begin
          if (level_q == LAST_LEVEL) begin
            state_d = DONE;
          end else begin
            level_d = level_q + LEVEL_W'(1);
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      LOSE_HOLD: begin
        if (hold_exit) state_d = LOAD;
        else           cnt_d   = cnt_q + HOLD_W'(1);
      end
      DONE: begin
        if (key_start) begin
          level_d = '0;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output flags follow the next state so they line up with the state register.
  always_comb begin
    load_req_d   = (state_d == LOAD);
    core_reset_d = (state_d == LOAD) && (state_q != LOAD);
    play_en_d    = (state_d == PLAY);
    show_win_d   = (state_d == WIN_HOLD);
    show_lose_d  = (state_d == LOSE_HOLD);
    all_clear_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= '0;
      cnt_q        <= '0;
      load_req_q   <= 1'b0;
      core_reset_q <= 1'b0;
      play_en_q    <= 1'b0;
      show_win_q   <= 1'b0;
      show_lose_q  <= 1'b0;
      all_clear_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      load_req_q   <= load_req_d;
      core_reset_q <= core_reset_d;
      play_en_q    <= play_en_d;
      show_win_q   <= show_win_d;
      show_lose_q  <= show_lose_d;
      all_clear_q  <= all_clear_d;
    end
  end

  assign level      = level_q;
  assign load_req   = load_req_q;
  assign core_reset = core_reset_q;
  assign play_en    = play_en_q;
  assign show_win   = show_win_q;
  assign show_lose  = show_lose_q;
  assign all_clear  = all_clear_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed vector table for the flow scenarios,
// then random stimulus against a behavioural game-flow model.
module tb_level_sequencer;

  localparam int unsigned NL   = 3;
  localparam int unsigned LW   = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned HW   = 2;

  logic          clk = 1'b0;
  logic          reset, key_start, key_restart, win, lose, load_done;
  logic [LW-1:0] level;
  logic          load_req, core_reset, play_en, show_win, show_lose, all_clear;

  level_sequencer #(.NUM_LEVELS(NL), .LEVEL_W(LW), .HOLD_CYCLES(HOLD), .HOLD_W(HW)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_restart(key_restart),
    .win(win), .lose(lose), .load_done(load_done), .level(level),
    .load_req(load_req), .core_reset(core_reset), .play_en(play_en),
    .show_win(show_win), .show_lose(show_lose), .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  // inputs: {reset, key_start, key_restart, win, lose, load_done}
  // outs:   {load_req, core_reset, play_en, show_win, show_lose, all_clear}
  typedef struct {
    logic [5:0] in;
    logic [1:0] lvl;
    logic [5:0] outs;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: phase names as strings, banner as a countdown of cycles left.
  string m_phase;
  int    m_level;
  int    m_left;
  bit    m_first;

  function automatic vec_t mk(input logic [5:0] i, input logic [1:0] l, input logic [5:0] o);
    vec_t v;
    v.in = i; v.lvl = l; v.outs = o;
    return v;
  endfunction

  function automatic logic [5:0] dut_outs();
    return {load_req, core_reset, play_en, show_win, show_lose, all_clear};
  endfunction

  function automatic logic [5:0] model_outs();
    return {m_phase == "load", m_first, m_phase == "play",
            m_phase == "win", m_phase == "lose", m_phase == "done"};
  endfunction

  task automatic model_step(input logic [5:0] i);
    bit rst, st, rs, w, l, ld;
    {rst, st, rs, w, l, ld} = i;
    m_first = 0;
    if (rst) begin
      m_phase = "idle"; m_level = 0; m_left = 0;
    end else if (m_phase == "idle") begin
      if (st) begin m_phase = "load"; m_first = 1; end
    end else if (m_phase == "load") begin
      if (ld) m_phase = "play";
    end else if (m_phase == "play") begin
      if (w)       begin m_phase = "win";  m_left = HOLD; end
      else if (l)  begin m_phase = "lose"; m_left = HOLD; end
      else if (rs) begin m_phase = "load"; m_first = 1; end
    end else if (m_phase == "win" || m_phase == "lose") begin
      m_left = m_left - 1;
      if (m_left == 0 || st) begin
        if (m_phase == "win" && m_level == NL - 1) begin
          m_phase = "done";
        end else begin
          if (m_phase == "win") m_level = m_level + 1;
          m_phase = "load"; m_first = 1;
        end
      end
    end else if (m_phase == "done") begin
      if (st) begin m_level = 0; m_phase = "load"; m_first = 1; end
    end
  endtask

  // Drive one cycle of inputs, update the model at the edge, settle, return.
  task automatic cycle(input logic [5:0] i);
    @(negedge clk);
    {reset, key_start, key_restart, win, lose, load_done} = i;
    @(posedge clk);
    model_step(i);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] got_o, input logic [5:0] exp_o,
                       input logic [1:0] got_l, input int exp_l);
    checks++;
    if (got_o !== exp_o || got_l !== LW'(exp_l)) begin
      failures++;
      $display("FAIL %s: got level=%0d outs=%b, expected level=%0d outs=%b",
               name, got_l, got_o, exp_l, exp_o);
    end
  endtask

  initial begin
    {reset, key_start, key_restart, win, lose, load_done} = 6'b100000;
    m_phase = "idle"; m_level = 0; m_left = 0; m_first = 0;

    tbl.push_back(mk(6'b100000, 2'd0, 6'b000000)); // reset
    tbl.push_back(mk(6'b001000, 2'd0, 6'b000000)); // restart ignored in IDLE
    tbl.push_back(mk(6'b000110, 2'd0, 6'b000000)); // win/lose ignored in IDLE
    tbl.push_back(mk(6'b010000, 2'd0, 6'b110000)); // start -> LOAD, core_reset
    tbl.push_back(mk(6'b001000, 2'd0, 6'b100000)); // restart ignored in LOAD
    tbl.push_back(mk(6'b000000, 2'd0, 6'b100000));
    tbl.push_back(mk(6'b000001, 2'd0, 6'b001000)); // load_done -> PLAY
    tbl.push_back(mk(6'b000110, 2'd0, 6'b000100)); // win beats lose
    tbl.push_back(mk(6'b000110, 2'd0, 6'b000100));
    tbl.push_back(mk(6'b001110, 2'd0, 6'b000100)); // restart ignored in hold
    tbl.push_back(mk(6'b000110, 2'd0, 6'b000100));
    tbl.push_back(mk(6'b000110, 2'd1, 6'b110000)); // 4-cycle banner -> LOAD lvl1
    tbl.push_back(mk(6'b000110, 2'd1, 6'b100000)); // stale win in LOAD
    tbl.push_back(mk(6'b000001, 2'd1, 6'b001000));
    tbl.push_back(mk(6'b000010, 2'd1, 6'b000010)); // lose
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000010));
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000010));
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000010));
    tbl.push_back(mk(6'b000000, 2'd1, 6'b110000)); // retry same level
    tbl.push_back(mk(6'b000001, 2'd1, 6'b001000));
    tbl.push_back(mk(6'b000010, 2'd1, 6'b000010)); // lose again
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000010));
    tbl.push_back(mk(6'b010000, 2'd1, 6'b110000)); // skip on 2nd banner cycle
    tbl.push_back(mk(6'b000001, 2'd1, 6'b001000));
    tbl.push_back(mk(6'b001000, 2'd1, 6'b110000)); // restart in PLAY
    tbl.push_back(mk(6'b000001, 2'd1, 6'b001000));
    tbl.push_back(mk(6'b000100, 2'd1, 6'b000100)); // win level 1
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd1, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd2, 6'b110000));
    tbl.push_back(mk(6'b000001, 2'd2, 6'b001000));
    tbl.push_back(mk(6'b000100, 2'd2, 6'b000100)); // win last level
    tbl.push_back(mk(6'b000000, 2'd2, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd2, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd2, 6'b000100));
    tbl.push_back(mk(6'b000000, 2'd2, 6'b000001)); // DONE
    tbl.push_back(mk(6'b001000, 2'd2, 6'b000001)); // restart ignored in DONE
    tbl.push_back(mk(6'b000001, 2'd2, 6'b000001)); // load_done ignored
    tbl.push_back(mk(6'b010000, 2'd0, 6'b110000)); // replay from level 0
    tbl.push_back(mk(6'b100000, 2'd0, 6'b000000)); // reset in LOAD
    tbl.push_back(mk(6'b000001, 2'd0, 6'b000000)); // late load_done ignored
    tbl.push_back(mk(6'b010000, 2'd0, 6'b110000));
    tbl.push_back(mk(6'b000001, 2'd0, 6'b001000));
    tbl.push_back(mk(6'b000100, 2'd0, 6'b000100));
    tbl.push_back(mk(6'b100000, 2'd0, 6'b000000)); // reset in WIN_HOLD
    tbl.push_back(mk(6'b000000, 2'd0, 6'b000000));

    for (int k = 0; k < tbl.size(); k++) begin
      cycle(tbl[k].in);
      check($sformatf("vec%0d", k), dut_outs(), tbl[k].outs, level, int'(tbl[k].lvl));
    end

    for (int n = 0; n < 3000; n++) begin
      logic [5:0] i;
      i[5] = ($urandom_range(63) == 0);
      i[4] = ($urandom_range(7) == 0);
      i[3] = ($urandom_range(9) == 0);
      i[2] = ($urandom_range(5) == 0);
      i[1] = ($urandom_range(5) == 0);
      i[0] = ($urandom_range(3) == 0);
      cycle(i);
      check($sformatf("rand%0d", n), dut_outs(), model_outs(), level, m_level);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
